// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and holds the IF/ID pipeline register that feeds decode.
// Optional build macro IF_PERF_CNT_EN adds the fetch_cnt and bubble_cnt outputs.
module if_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [7:0]  RESET_PC  = 8'h00,
    localparam int unsigned AW = 8,
    localparam int unsigned IW = 16,
    localparam int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hazard,
    input  logic          B,
    input  logic [AW-1:0] Br_addr,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] Instruction,
    output logic [AW-1:0] PC_out,
`ifdef IF_PERF_CNT_EN
    output logic [CW-1:0] fetch_cnt,
    output logic [CW-1:0] bubble_cnt,
`endif
    output logic          valid
);

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;

    // Sequential successor; wraps 8'hFF -> 8'h00 by construction.
    assign pc_inc    = pc + AW'(1);
    // The PC register drives memory directly, so hazard/B never reach the address combinationally.
    assign imem_addr = pc;

    // Program counter: redirect beats freeze beats sequential advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (B) begin
            pc <= Br_addr;
        end else if (!hazard) begin
            pc <= pc_inc;
        end
    end

    // IF/ID register: flush on redirect (branch-cycle fetch is discarded), hold on freeze.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Instruction <= NOP_INSTR;
            PC_out      <= '0;
            valid       <= 1'b0;
        end else if (B) begin
            Instruction <= NOP_INSTR;
            PC_out      <= '0;
            valid       <= 1'b0;
        end else if (!hazard) begin
            Instruction <= imem_rdata;
            PC_out      <= pc_inc;
            valid       <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Saturating counters: real loads versus redirect/freeze bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (B || hazard) begin
            if (bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CW'(1);
            end
        end else begin
            if (fetch_cnt != CNT_MAX) begin
                fetch_cnt <= fetch_cnt + CW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory model returns 16'h1000 + address.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        hazard;
    logic        B;
    logic [7:0]  Br_addr;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] Instruction;
    logic [7:0]  PC_out;
    logic        valid;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] bubble_cnt;
    logic [15:0] fc_snap;
    logic [15:0] bc_snap;
`endif

    int n_checks = 0;
    int n_errors = 0;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .hazard      (hazard),
        .B           (B),
        .Br_addr     (Br_addr),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .PC_out      (PC_out),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt),
`endif
        .valid       (valid)
    );

    // Combinational instruction memory.
    assign imem_rdata = 16'h1000 + {8'h00, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] ins, input logic [7:0] pco,
                              input logic vld, input logic [7:0] pc);
        check({tag, ".instr"}, Instruction, ins);
        check({tag, ".pc_out"}, 16'(PC_out), 16'(pco));
        check({tag, ".valid"}, 16'(valid), 16'(vld));
        check({tag, ".pc"}, 16'(imem_addr), 16'(pc));
    endtask

    initial begin
        rst = 1'b0; hazard = 1'b0; B = 1'b0; Br_addr = 8'h00;
        #3;
        check_ifid("reset", 16'h0000, 8'h00, 1'b0, 8'h00);
`ifdef IF_PERF_CNT_EN
        check("reset.fetch_cnt", fetch_cnt, 16'h0000);
        check("reset.bubble_cnt", bubble_cnt, 16'h0000);
`endif
        #9 rst = 1'b1;  // t=12, mid-cycle

        // Free run: after edge k, IF/ID holds addr k-1 with PC_out k.
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_ifid($sformatf("run%0d", k), 16'h1000 + 16'(k - 1), 8'(k), 1'b1, 8'(k));
        end

        // Redirect to 8'hFE then run through the wrap.
        B = 1'b1; Br_addr = 8'hFE;
        tick();
        check_ifid("br_fe", 16'h0000, 8'h00, 1'b0, 8'hFE);
        B = 1'b0;
        tick();
        check_ifid("wrap0", 16'h10FE, 8'hFF, 1'b1, 8'hFF);
        tick();
        check_ifid("wrap1", 16'h10FF, 8'h00, 1'b1, 8'h00);

        // Advance to PC=5, then freeze for three edges.
        repeat (5) tick();
        check_ifid("pre_hz", 16'h1004, 8'h05, 1'b1, 8'h05);
        hazard = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_ifid($sformatf("hz%0d", k), 16'h1004, 8'h05, 1'b1, 8'h05);
        end
        hazard = 1'b0;
        tick();
        check_ifid("hz_rel", 16'h1005, 8'h06, 1'b1, 8'h06);

        // Get PC to 8'h10, then take a branch to 8'h40.
        B = 1'b1; Br_addr = 8'h10;
        tick();
        B = 1'b1; Br_addr = 8'h40;
        tick();
        check_ifid("br40", 16'h0000, 8'h00, 1'b0, 8'h40);
        B = 1'b0;
        tick();
        check_ifid("br40_tgt", 16'h1040, 8'h41, 1'b1, 8'h41);

        // B and hazard together: branch wins.
`ifdef IF_PERF_CNT_EN
        fc_snap = fetch_cnt;
        bc_snap = bubble_cnt;
`endif
        B = 1'b1; hazard = 1'b1; Br_addr = 8'h22;
        tick();
        check_ifid("b_hz", 16'h0000, 8'h00, 1'b0, 8'h22);
`ifdef IF_PERF_CNT_EN
        check("b_hz.fetch_cnt", fetch_cnt, fc_snap);
        check("b_hz.bubble_cnt", bubble_cnt, bc_snap + 16'h0001);
`endif
        hazard = 1'b0;

        // Self-loop: branch to the current PC, one bubble per iteration.
        Br_addr = 8'h22;
        tick();
        check_ifid("self_loop", 16'h0000, 8'h00, 1'b0, 8'h22);
        B = 1'b0;
        tick();
        check_ifid("self_tgt", 16'h1022, 8'h23, 1'b1, 8'h23);

        // Reach PC=8'h33 then assert reset asynchronously mid-cycle.
        B = 1'b1; Br_addr = 8'h32;
        tick();
        B = 1'b0;
        tick();
        check_ifid("pre_rst", 16'h1032, 8'h33, 1'b1, 8'h33);
        #2 rst = 1'b0;
        #1;
        check_ifid("async_rst", 16'h0000, 8'h00, 1'b0, 8'h00);
`ifdef IF_PERF_CNT_EN
        check("async_rst.fetch_cnt", fetch_cnt, 16'h0000);
        check("async_rst.bubble_cnt", bubble_cnt, 16'h0000);
`endif
        rst = 1'b1;
        tick();
        check_ifid("post_rst", 16'h1000, 8'h01, 1'b1, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 8-bit-address, 16-bit-instruction pipeline, directly upstream of the decode stage.
- Owns the program counter and drives the instruction-memory address.
- Contains the IF/ID pipeline register that feeds decode with the instruction and PC+1, which decode latches as the link address.
- Takes branch redirect (B, Br_addr) and freeze (hazard) back from decode and the hazard unit.

Parameters:
NOP_INSTR, 16'h0000, instruction word injected into IF/ID on reset and on flush
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
hazard  in  1  freeze request from hazard-detect unit
B  in  1  branch taken, from decode stage
Br_addr  in  8  branch/return target, from decode stage
imem_addr  out  8  instruction memory word address (= PC)
imem_rdata  in  16  instruction word at imem_addr, combinational read
Instruction  out  16  IF/ID register: instruction to decode
PC_out  out  8  IF/ID register: PC+1 of the fetched instruction
valid  out  1  IF/ID register holds a real instruction (0 = bubble)

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - PC=RESET_PC, Instruction=NOP_INSTR, PC_out=8'h00, valid=0.
  - Optional counters clear to 0.
- imem_addr = PC, combinational. Memory is word-addressed; PC steps by 1 per instruction.
- PC update, evaluated per rising edge in priority order:
  - B=1: PC <= Br_addr.
  - else hazard=1: PC holds.
  - else: PC <= PC+1, 8-bit modulo (8'hFF -> 8'h00, no flag).
- IF/ID update, same edge, same priority:
  - B=1 (flush): Instruction <= NOP_INSTR, PC_out <= 8'h00, valid <= 0. The instruction fetched in the branch cycle is discarded.
  - else hazard=1: Instruction, PC_out and valid all hold their values.
  - else: Instruction <= imem_rdata, PC_out <= PC+1 (8-bit wrap), valid <= 1.
- Latency: one cycle from PC to IF/ID output.
- Taken-branch penalty: exactly one bubble. The cycle after B=1, decode sees valid=0 / NOP_INSTR. The cycle after that, it sees the instruction at Br_addr.
- Simultaneous B and hazard: B wins (redirect and flush). Decode already masks B under hazard, so this is a defensive rule and must still be implemented.
- Hazard held for N cycles: PC and IF/ID are frozen for N cycles. No instruction is lost or duplicated on release.
- Reset released mid-stream: the first rising edge with rst=1 fetches RESET_PC. No residual state survives reset.
- Branch to the current PC value (self-loop): legal. The stage refetches the same address indefinitely with one bubble per iteration.
- No combinational path from hazard or B to imem_addr. Both act only at the clock edge.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[15:0] and bubble_cnt[15:0].
  - fetch_cnt increments on every edge where IF/ID loads a real instruction (no B, no hazard).
  - bubble_cnt increments on every edge where B=1, or where hazard=1 with B=0.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counter logic are absent. The rest of the behaviour is identical.

Test Plan:
- Reset then free-run, imem returns 16'h1000+addr, no B/hazard → after edge k (k≥1): Instruction=16'h1000+(k-1), PC_out=k, valid=1.
- Free-run through wrap → PC sequence 8'hFE, 8'hFF, 8'h00. IF/ID shows addr 8'hFF with PC_out=8'h00.
- hazard=1 for 3 cycles while PC=8'h05 → PC stays 8'h05, Instruction/PC_out/valid frozen. After release, next load is addr 5, PC_out=8'h06.
- B=1, Br_addr=8'h40 while PC=8'h10 → next edge: valid=0, Instruction=NOP_INSTR, PC=8'h40. Edge after: Instruction=imem[8'h40], PC_out=8'h41.
- B=1 and hazard=1 same cycle, Br_addr=8'h22 → PC=8'h22, IF/ID flushed. With IF_PERF_CNT_EN, bubble_cnt +1 and fetch_cnt unchanged.
- rst pulled low asynchronously mid-cycle with PC=8'h33 → outputs reset immediately without waiting for a clock edge. First edge after release fetches 8'h00.
